// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier family.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } seq_mul_state_t;

  localparam int SEQ_MUL_DEFAULT_WIDTH = 32;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int seq_mul_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul_abs.sv
// Conditional two's-complement magnitude of one operand, plus its sign.
module seq_mul_abs
  import mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_DEFAULT_WIDTH
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign neg = is_signed & val[WIDTH-1];
  assign mag = neg ? (~val + {{(WIDTH-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/seq_mul_shift_add.sv
// Sequential shift-add multiplier, full 2*WIDTH product, start/done handshake.
// Optional early termination on an exhausted multiplier: SEQ_MUL_EARLY_TERM_EN.
module seq_mul_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = seq_mul_cnt_w(WIDTH);

  seq_mul_state_t     state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] addend;
  logic               early_exit;

  seq_mul_abs #(.WIDTH(WIDTH)) u_abs_a (.is_signed(is_signed), .val(a), .mag(a_mag), .neg(a_neg));
  seq_mul_abs #(.WIDTH(WIDTH)) u_abs_b (.is_signed(is_signed), .val(b), .mag(b_mag), .neg(b_neg));

  assign addend = {{WIDTH{1'b0}}, mcand_q} << count_q;

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign early_exit = (mplier_q == {WIDTH{1'b0}});
`else
  assign early_exit = 1'b0;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = {(2*WIDTH){1'b0}};
          count_d  = {CW{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        if (early_exit) begin
          state_d = SIGN;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + addend;
          end else begin
            acc_d = acc_q;
          end
          mplier_d = mplier_q >> 1;
          count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = SIGN;
          end else begin
            state_d = CALC;
          end
        end
      end
      SIGN: begin
        result_d = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      count_q  <= {CW{1'b0}};
      neg_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Scoreboard bench for seq_mul_shift_add (WIDTH=32); honours SEQ_MUL_EARLY_TERM_EN.
module tb_seq_mul_shift_add;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        ready, busy, done;
  logic [63:0] result;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   pass = 0;

  seq_mul_shift_add #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Expected edges from accept to done, derived from the multiplier magnitude.
  function automatic int lat(input logic [31:0] ib, input logic s);
    logic [31:0] m;
    int msb;
    m = (s && ib[31]) ? (~ib + 32'd1) : ib;
`ifdef SEQ_MUL_EARLY_TERM_EN
    if (m == 32'd0) return 2;
    msb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
    return (msb + 3 < 33) ? msb + 3 : 33;
`else
    msb = 0;
    return 33 + msb;
`endif
  endfunction

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic s, input logic [63:0] er);
    int n = 0;
    exp_t e;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    if (!ready) begin
      total++;
      $display("FAIL issue_timeout: ready=%0b expected 1", ready);
    end else begin
      a = ia; b = ib; is_signed = s; start = 1'b1;
      e.res = er;
      e.due = cyc + 1 + lat(ib, s);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0 || !ready) begin
      total++;
      $display("FAIL done_timeout: pending=%0d expected 0", sb.size());
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: result=%h expected no done", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);

    issue(32'd15, 32'd10, 1'b1, 64'd150);                              wait_idle();
    issue(32'hFFFF_FFF9, 32'd14, 1'b1, 64'hFFFF_FFFF_FFFF_FF9E);       wait_idle();
    issue(32'd15, 32'hFFFF_FFF6, 1'b1, 64'hFFFF_FFFF_FFFF_FF6A);       wait_idle();
    issue(32'hFFFF_FFF1, 32'hFFFF_FFF6, 1'b1, 64'd150);                wait_idle();
    issue(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);        wait_idle();
    issue(32'hFFFF_FB2E, 32'd5678, 1'b1, 64'hFFFF_FFFF_FF95_1644);     wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001); wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);                  wait_idle();
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 64'd0);                          wait_idle();
    issue(32'd5, 32'd0, 1'b0, 64'd0);                                  wait_idle();
    issue(32'd9, 32'd1, 1'b0, 64'd9);                                  wait_idle();
    issue(32'd3, 32'h8000_0000, 1'b0, 64'h0000_0001_8000_0000);        wait_idle();

    // Starts while busy must be ignored.
    issue(32'd15, 32'd10, 1'b1, 64'd150);
    repeat (3) @(negedge clk);
    a = 32'd7; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    a = 32'd99; b = 32'hFFFF_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: second start lands in the done cycle.
    issue(32'd6, 32'd7, 1'b0, 64'd42);
    issue(32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_idle();

    // Abort mid-CALC.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", result, 64'd0);
    repeat (40) @(negedge clk);
    issue(32'd3, 32'd4, 1'b0, 64'd12);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
